wb_vec_pic: RTL and testbench

Parametrised successor to simple_pic: an N-channel vectored interrupt controller for the Zet system bus.
- Edge-detects peripheral interrupt requests (timer, keyboard, com1, ...) and presents intr to the cpu wb_tgc_i.
- Returns an 8-bit vector during the cpu inta (wb_tgc_o) cycle.
- Adds features simple_pic lacks: fixed priority, in-service tracking, mask register, non-specific EOI over a Wishbone I/O slave port.
- Sits between the peripherals and the cpu; the top level muxes vec_o onto dat_i while inta is high.

---
 rtl/wb_vec_pic.sv | 123 ++++++++++++
 tb/tb_wb_vec_pic.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_vec_pic.sv
// wb_vec_pic: N-channel vectored interrupt controller with Wishbone I/O port.
// Optional macro PIC_AUTO_EOI_EN: acknowledge never sets ISR; EOI writes ignored.
module wb_vec_pic #(
    parameter int         NUM_IRQ  = 8,
    parameter logic [7:0] VEC_BASE = 8'h08
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               inta_i,
    output logic               intr_o,
    output logic [7:0]         vec_o,
    input  logic               wb_adr_i,
    input  logic [7:0]         wb_dat_i,
    output logic [7:0]         wb_dat_o,
    input  logic               wb_we_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic               wb_ack_o
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] isr;
    logic [NUM_IRQ-1:0] imr;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] edges;
    logic [NUM_IRQ-1:0] win_hot;
    logic [NUM_IRQ-1:0] eoi_hot;
    logic [NUM_IRQ-1:0] irr_nxt;
    logic [NUM_IRQ-1:0] isr_nxt;
    logic               inta_q;
    logic               any;
    logic               blocked;
    logic               unblocked;
    logic               ack_edge;
    logic               acc;
    logic               wr;
    logic               eoi;
    logic [2:0]         win;
    logic [2:0]         iid;
    logic [7:0]         irr8;
    logic [7:0]         imr8;
    logic [7:0]         rd_data;

    // Arbitration, handshake decode and next-state for IRR/ISR
    always_comb begin
        elig = irr & ~imr;
        win  = '0;
        any  = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win = 3'(i);
                any = 1'b1;
            end
        end
        blocked = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (isr[i] && (3'(i) <= win))
                blocked = 1'b1;
        end
        unblocked    = any & ~blocked;
        win_hot      = '0;
        win_hot[win] = 1'b1;
        ack_edge     = inta_i & ~inta_q;
        acc          = wb_stb_i & wb_cyc_i & ~wb_ack_o;
        wr           = acc & wb_we_i;
        eoi          = wr & ~wb_adr_i & wb_dat_i[5];
        eoi_hot      = isr & (-isr);
        edges        = irq_i & ~irq_q;
        iid          = unblocked ? win : 3'(NUM_IRQ - 1);

        irr_nxt = irr;
        if (ack_edge && unblocked)
            irr_nxt = irr_nxt & ~win_hot;
        irr_nxt = irr_nxt | edges;

`ifdef PIC_AUTO_EOI_EN
        isr_nxt = '0;
`else
        isr_nxt = isr;
        if (eoi)
            isr_nxt = isr_nxt & ~eoi_hot;
        if (ack_edge && unblocked)
            isr_nxt = isr_nxt | win_hot;
`endif

        irr8                = '0;
        irr8[NUM_IRQ-1:0]   = irr;
        imr8                = '0;
        imr8[NUM_IRQ-1:0]   = imr;
        rd_data             = wb_adr_i ? imr8 : irr8;
    end

    // Register state, interrupt output, vector and bus response
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_q    <= '0;
            inta_q   <= 1'b0;
            irr      <= '0;
            isr      <= '0;
            imr      <= '0;
            intr_o   <= 1'b0;
            vec_o    <= VEC_BASE;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            irq_q    <= irq_i;
            inta_q   <= inta_i;
            irr      <= irr_nxt;
            isr      <= isr_nxt;
            intr_o   <= ack_edge ? 1'b0 : unblocked;
            wb_ack_o <= acc;
            if (ack_edge)
                vec_o <= VEC_BASE + {5'b00000, iid};
            if (acc)
                wb_dat_o <= rd_data;
            if (wr && wb_adr_i)
                imr <= wb_dat_i[NUM_IRQ-1:0];
        end
    end

endmodule

// File: tb/tb_wb_vec_pic.sv
// tb_wb_vec_pic: directed table-driven bench for wb_vec_pic.
// Table rows are one clock each; hand sequences cover nesting and corner cases.
module tb_wb_vec_pic;

    logic       clk;
    logic       rst;
    logic [7:0] irq;
    logic       inta;
    logic       intr;
    logic [7:0] vec;
    logic       adr;
    logic [7:0] dat;
    logic [7:0] dat_o;
    logic       we;
    logic       stb;
    logic       ack;

    int checks;
    int failures;

    wb_vec_pic #(.NUM_IRQ(8), .VEC_BASE(8'h08)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .irq_i    (irq),
        .inta_i   (inta),
        .intr_o   (intr),
        .vec_o    (vec),
        .wb_adr_i (adr),
        .wb_dat_i (dat),
        .wb_dat_o (dat_o),
        .wb_we_i  (we),
        .wb_stb_i (stb),
        .wb_cyc_i (stb),
        .wb_ack_o (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic       inta;
        logic       stb;
        logic       we;
        logic       adr;
        logic [7:0] dat;
        logic       e_intr;
        logic [7:0] e_vec;
        logic       e_ack;
        logic       chk_dat;
        logic [7:0] e_dat;
    } row_t;

    row_t tbl[21];

    function automatic row_t mk(
        input logic r, input logic [7:0] q, input logic a,
        input logic s, input logic w, input logic ad, input logic [7:0] d,
        input logic ei, input logic [7:0] ev, input logic ea,
        input logic cd, input logic [7:0] ed);
        row_t t;
        t.rst = r; t.irq = q; t.inta = a; t.stb = s; t.we = w;
        t.adr = ad; t.dat = d; t.e_intr = ei; t.e_vec = ev;
        t.e_ack = ea; t.chk_dat = cd; t.e_dat = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic a, input logic [7:0] d);
        stb = 1'b1; we = 1'b1; adr = a; dat = d;
        step();
        chk("wr_ack", ack, 1);
        stb = 1'b0; we = 1'b0; dat = 8'h00;
        step();
    endtask

    task automatic bus_rd(input logic a, output logic [7:0] d);
        stb = 1'b1; we = 1'b0; adr = a;
        step();
        chk("rd_ack", ack, 1);
        d = dat_o;
        stb = 1'b0;
        step();
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq = m;
        step();
        irq = 8'h00;
        step();
    endtask

    task automatic do_inta(output logic [7:0] v);
        inta = 1'b1;
        step();
        v = vec;
        inta = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] rd;
        int         deliveries;

        checks = 0; failures = 0;
        rst = 1'b1; irq = 8'h00; inta = 1'b0;
        stb = 1'b0; we = 1'b0; adr = 1'b0; dat = 8'h00;

        //        rst irq  inta stb we adr dat    intr vec   ack cd dat
        tbl[0]  = mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h08, 0, 1, 8'h00);
        tbl[1]  = mk(0, 8'h08, 0, 0, 0, 0, 8'h00, 0, 8'h08, 0, 0, 8'h00);
        tbl[2]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h08, 0, 0, 8'h00);
        tbl[3]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[4]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[5]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 8'h0B, 1, 1, 8'h00);
        tbl[6]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[7]  = mk(0, 8'h00, 0, 1, 1, 0, 8'h20, 0, 8'h0B, 1, 0, 8'h00);
        tbl[8]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[9]  = mk(0, 8'h00, 0, 1, 1, 1, 8'h08, 0, 8'h0B, 1, 0, 8'h00);
        tbl[10] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[11] = mk(0, 8'h08, 0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[12] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[13] = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 8'h0B, 1, 1, 8'h08);
        tbl[14] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[15] = mk(0, 8'h00, 0, 1, 1, 1, 8'h00, 0, 8'h0B, 1, 0, 8'h00);
        tbl[16] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h0B, 0, 0, 8'h00);
        tbl[17] = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[18] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);
        tbl[19] = mk(0, 8'h00, 0, 1, 1, 0, 8'h20, 0, 8'h0B, 1, 0, 8'h00);
        tbl[20] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 8'h00);

        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst; irq = tbl[i].irq; inta = tbl[i].inta;
            stb = tbl[i].stb; we = tbl[i].we; adr = tbl[i].adr;
            dat = tbl[i].dat;
            step();
            chk($sformatf("row%0d_intr", i), intr, tbl[i].e_intr);
            chk($sformatf("row%0d_vec", i), vec, tbl[i].e_vec);
            chk($sformatf("row%0d_ack", i), ack, tbl[i].e_ack);
            if (tbl[i].chk_dat)
                chk($sformatf("row%0d_dat", i), dat_o, tbl[i].e_dat);
            if (i == 3)
                chk("t1_isr", dut.isr, 8'h08);
        end
        stb = 1'b0; we = 1'b0; dat = 8'h00; irq = 8'h00; inta = 1'b0;
        chk("tbl_isr_clear", dut.isr, 8'h00);

        // priority and blocking until EOI
        pulse_irq(8'h22);
        chk("t2_intr", intr, 1);
        do_inta(v);
        chk("t2_vec1", v, 8'h09);
        chk("t2_isr", dut.isr, 8'h02);
        step();
        step();
        chk("t2_blocked", intr, 0);
        bus_wr(1'b0, 8'h20);
        chk("t2_unblock", intr, 1);
        do_inta(v);
        chk("t2_vec2", v, 8'h0D);
        bus_wr(1'b0, 8'h20);
        chk("t2_isr0", dut.isr, 8'h00);

        // nesting a higher priority request over an in-service one
        pulse_irq(8'h10);
        do_inta(v);
        chk("t3_vec4", v, 8'h0C);
        pulse_irq(8'h04);
        chk("t3_nest_intr", intr, 1);
        do_inta(v);
        chk("t3_vec2", v, 8'h0A);
        chk("t3_isr14", dut.isr, 8'h14);
        bus_wr(1'b0, 8'h20);
        chk("t3_isr10", dut.isr, 8'h10);
        bus_wr(1'b0, 8'h00);
        chk("t3_eoi_ign", dut.isr, 8'h10);
        bus_wr(1'b0, 8'h20);
        chk("t3_isr0", dut.isr, 8'h00);
        bus_wr(1'b0, 8'h20);
        chk("t3_eoi_noop", dut.isr, 8'h00);

        // held-high line delivers once
        irq = 8'h01;
        deliveries = 0;
        for (int k = 0; k < 30; k++) begin
            if (intr) begin
                do_inta(v);
                deliveries++;
                bus_wr(1'b0, 8'h20);
            end else begin
                step();
            end
        end
        chk("t5_once", deliveries, 1);
        irq = 8'h00;
        step();
        do_inta(v);
        chk("t5_spur_vec", v, 8'h0F);
        chk("t5_spur_isr", dut.isr, 8'h00);
        chk("t5_spur_intr", intr, 0);
        bus_rd(1'b0, rd);
        chk("t5_spur_irr", rd, 8'h00);

        // EOI and acknowledge in the same cycle
        pulse_irq(8'h02);
        do_inta(v);
        pulse_irq(8'h01);
        chk("sim_intr", intr, 1);
        inta = 1'b1; stb = 1'b1; we = 1'b1; adr = 1'b0; dat = 8'h20;
        step();
        chk("sim_ack", ack, 1);
        chk("sim_vec", vec, 8'h08);
        chk("sim_isr", dut.isr, 8'h01);
        inta = 1'b0; stb = 1'b0; we = 1'b0; dat = 8'h00;
        step();
        bus_wr(1'b0, 8'h20);
        chk("sim_isr0", dut.isr, 8'h00);

        // reset in the middle of activity
        pulse_irq(8'h02);
        do_inta(v);
        pulse_irq(8'h01);
        do_inta(v);
        chk("t6_isr03", dut.isr, 8'h03);
        pulse_irq(8'h40);
        bus_wr(1'b1, 8'h80);
        bus_rd(1'b0, rd);
        chk("t6_irr40", rd, 8'h40);
        rst = 1'b1; stb = 1'b1; adr = 1'b1;
        step();
        chk("t6_rst_intr", intr, 0);
        chk("t6_rst_vec", vec, 8'h08);
        chk("t6_rst_ack", ack, 0);
        chk("t6_rst_dat", dat_o, 8'h00);
        chk("t6_rst_isr", dut.isr, 8'h00);
        rst = 1'b0; stb = 1'b0;
        step();
        bus_rd(1'b0, rd);
        chk("t6_irr0", rd, 8'h00);
        bus_rd(1'b1, rd);
        chk("t6_imr0", rd, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
